// File: rtl/inta_sequencer.sv
// CPU-side interrupt-acknowledge initiator: issues the INTA pulse train to the PIC
// and captures the vector byte (8086) or the CALL target address (MCS-80/85).
module inta_sequencer #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        intr,
  input  logic        ien,
  input  logic        mode,
  input  logic [7:0]  D,
  output logic        inta,
  output logic        busy,
  output logic        vec_valid,
  output logic [7:0]  vector,
  output logic [15:0] call_addr,
  output logic        opcode_err
);

  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_W - 1);
  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        pcnt_q, pcnt_d;
  logic              mode_q, mode_d;
  logic              inta_q, inta_d;
  logic [7:0]        vector_q, vector_d;
  logic [15:0]       call_addr_q, call_addr_d;
  logic              opcode_err_q, opcode_err_d;

  logic start;
  logic low_end;
  logic gap_end;
  logic last_pulse;

  assign start      = (state_q == IDLE) && intr && ien;
  assign low_end    = (state_q == LOW)  && (cnt_q == LOW_LAST);
  assign gap_end    = (state_q == HIGH) && (cnt_q == GAP_LAST);
  // 8086 needs two pulses, MCS three; the mode latched at start decides.
  assign last_pulse = mode_q ? (pcnt_q == 2'd1) : (pcnt_q == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pcnt_q       <= 2'd0;
      mode_q       <= 1'b0;
      inta_q       <= 1'b1;
      vector_q     <= 8'h00;
      call_addr_q  <= 16'h0000;
      opcode_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pcnt_q       <= pcnt_d;
      mode_q       <= mode_d;
      inta_q       <= inta_d;
      vector_q     <= vector_d;
      call_addr_q  <= call_addr_d;
      opcode_err_q <= opcode_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOW;
          cnt_d   = '0;
          pcnt_d  = 2'd0;
          mode_d  = mode;
        end
      end
      LOW: begin
        if (low_end) begin
          cnt_d   = '0;
          state_d = last_pulse ? DONE : HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (gap_end) begin
          cnt_d   = '0;
          pcnt_d  = pcnt_q + 2'd1;
          state_d = LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs and data capture; INTA is driven from a flop so it never glitches.
  always_comb begin
    inta_d       = (state_d != LOW);
    vector_d     = vector_q;
    call_addr_d  = call_addr_q;
    opcode_err_d = opcode_err_q;
    if (start) begin
      opcode_err_d = 1'b0;
    end
    if (low_end) begin
      if (mode_q) begin
        if (pcnt_q == 2'd1) begin
          vector_d = D;
        end
      end else begin
        unique case (pcnt_q)
          2'd0:    opcode_err_d = (D != CALL_OPCODE);
          2'd1:    call_addr_d[7:0]  = D;
          2'd2:    call_addr_d[15:8] = D;
          default: ;
        endcase
      end
    end
  end

  assign inta       = inta_q;
  assign busy       = (state_q != IDLE);
  assign vec_valid  = (state_q == DONE);
  assign vector     = vector_q;
  assign call_addr  = call_addr_q;
  assign opcode_err = opcode_err_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: cycle-by-cycle vector table on a default
// instance, plus hand sequences for async reset and a narrow-pulse instance.
module tb_inta_sequencer;

  logic        clk;
  logic        rst_n;
  logic        intr, ien, mode;
  logic [7:0]  d;
  logic        inta, busy, vv;
  logic [7:0]  vector;
  logic [15:0] call_addr;
  logic        oe;

  logic        intr_b, ien_b, mode_b;
  logic [7:0]  d_b;
  logic        inta_b, busy_b, vv_b;
  logic [7:0]  vector_b;
  logic [15:0] call_addr_b;
  logic        oe_b;

  int checks = 0;
  int errors = 0;

  inta_sequencer #(.PULSE_W(2), .GAP_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .intr(intr), .ien(ien), .mode(mode), .D(d),
    .inta(inta), .busy(busy), .vec_valid(vv), .vector(vector),
    .call_addr(call_addr), .opcode_err(oe)
  );

  inta_sequencer #(.PULSE_W(1), .GAP_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .intr(intr_b), .ien(ien_b), .mode(mode_b), .D(d_b),
    .inta(inta_b), .busy(busy_b), .vec_valid(vv_b), .vector(vector_b),
    .call_addr(call_addr_b), .opcode_err(oe_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        intr;
    logic        ien;
    logic        mode;
    logic [7:0]  d;
    logic        inta;
    logic        busy;
    logic        vv;
    logic [7:0]  vec;
    logic [15:0] ca;
    logic        oe;
  } row_t;

  row_t tbl[$];

  function automatic void add(input logic i, input logic e, input logic m, input logic [7:0] dd,
                              input logic xi, input logic xb, input logic xv,
                              input logic [7:0] xvec, input logic [15:0] xca, input logic xoe);
    row_t r;
    r.intr = i; r.ien = e; r.mode = m; r.d = dd;
    r.inta = xi; r.busy = xb; r.vv = xv; r.vec = xvec; r.ca = xca; r.oe = xoe;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  logic [13:0] exp_inta_b, exp_busy_b, exp_vv_b;

  initial begin
    rst_n = 1'b1;
    intr = 1'b0; ien = 1'b0; mode = 1'b0; d = 8'h00;
    intr_b = 1'b0; ien_b = 1'b0; mode_b = 1'b1; d_b = 8'h00;

    // 8086, mode toggled mid-sequence, intr dropped after E0+1
    add(1,1,1,8'h00, 0,1,0, 8'h00,16'h0000,0);
    add(1,1,1,8'h00, 0,1,0, 8'h00,16'h0000,0);
    add(0,1,0,8'h00, 1,1,0, 8'h00,16'h0000,0);
    add(0,1,0,8'h00, 1,1,0, 8'h00,16'h0000,0);
    add(0,1,0,8'h00, 0,1,0, 8'h00,16'h0000,0);
    add(0,1,0,8'h48, 0,1,0, 8'h00,16'h0000,0);
    add(0,1,1,8'h48, 1,1,1, 8'h48,16'h0000,0);
    add(0,1,1,8'h00, 1,0,0, 8'h48,16'h0000,0);
    // ien low gates the request
    add(1,0,0,8'h00, 1,0,0, 8'h48,16'h0000,0);
    add(1,0,0,8'h00, 1,0,0, 8'h48,16'h0000,0);
    // MCS good opcode, ien dropped and mode flipped mid-sequence
    add(1,1,0,8'h00, 0,1,0, 8'h48,16'h0000,0);
    add(1,0,1,8'h00, 0,1,0, 8'h48,16'h0000,0);
    add(1,0,1,8'hCD, 1,1,0, 8'h48,16'h0000,0);
    add(1,0,1,8'h00, 1,1,0, 8'h48,16'h0000,0);
    add(1,0,1,8'h00, 0,1,0, 8'h48,16'h0000,0);
    add(1,0,1,8'h00, 0,1,0, 8'h48,16'h0000,0);
    add(1,0,1,8'h20, 1,1,0, 8'h48,16'h0020,0);
    add(1,0,1,8'h00, 1,1,0, 8'h48,16'h0020,0);
    add(1,0,1,8'h00, 0,1,0, 8'h48,16'h0020,0);
    add(1,0,1,8'h00, 0,1,0, 8'h48,16'h0020,0);
    add(1,0,1,8'h1C, 1,1,1, 8'h48,16'h1C20,0);
    add(1,0,1,8'h00, 1,0,0, 8'h48,16'h1C20,0);
    // MCS bad opcode: error flagged, all pulses still issued
    add(1,1,0,8'h00, 0,1,0, 8'h48,16'h1C20,0);
    add(0,1,0,8'h00, 0,1,0, 8'h48,16'h1C20,0);
    add(0,1,0,8'h00, 1,1,0, 8'h48,16'h1C20,1);
    add(0,1,0,8'h00, 1,1,0, 8'h48,16'h1C20,1);
    add(0,1,0,8'h00, 0,1,0, 8'h48,16'h1C20,1);
    add(0,1,0,8'h00, 0,1,0, 8'h48,16'h1C20,1);
    add(0,1,0,8'h34, 1,1,0, 8'h48,16'h1C34,1);
    add(0,1,0,8'h00, 1,1,0, 8'h48,16'h1C34,1);
    add(0,1,0,8'h00, 0,1,0, 8'h48,16'h1C34,1);
    add(0,1,0,8'h00, 0,1,0, 8'h48,16'h1C34,1);
    add(0,1,0,8'h12, 1,1,1, 8'h48,16'h1234,1);
    add(0,1,0,8'h00, 1,0,0, 8'h48,16'h1234,1);
    // 8086 again: opcode_err cleared at start, call_addr held
    add(1,1,1,8'h00, 0,1,0, 8'h48,16'h1234,0);
    add(0,1,1,8'h00, 0,1,0, 8'h48,16'h1234,0);
    add(0,1,1,8'h00, 1,1,0, 8'h48,16'h1234,0);
    add(0,1,1,8'h00, 1,1,0, 8'h48,16'h1234,0);
    add(0,1,1,8'h00, 0,1,0, 8'h48,16'h1234,0);
    add(0,1,1,8'h00, 0,1,0, 8'h48,16'h1234,0);
    add(0,1,1,8'hA5, 1,1,1, 8'hA5,16'h1234,0);
    add(0,1,1,8'h00, 1,0,0, 8'hA5,16'h1234,0);

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_inta", 0, 16'(inta), 16'h1);
    chk("reset_busy", 0, 16'(busy), 16'h0);
    chk("reset_vv",   0, 16'(vv), 16'h0);
    chk("reset_vec",  0, 16'(vector), 16'h00);
    chk("reset_ca",   0, call_addr, 16'h0000);
    chk("reset_oe",   0, 16'(oe), 16'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      intr = tbl[i].intr; ien = tbl[i].ien; mode = tbl[i].mode; d = tbl[i].d;
      @(posedge clk);
      #1;
      chk("inta",      i, 16'(inta), 16'(tbl[i].inta));
      chk("busy",      i, 16'(busy), 16'(tbl[i].busy));
      chk("vec_valid", i, 16'(vv), 16'(tbl[i].vv));
      chk("vector",    i, 16'(vector), 16'(tbl[i].vec));
      chk("call_addr", i, call_addr, tbl[i].ca);
      chk("opcode_err",i, 16'(oe), 16'(tbl[i].oe));
    end

    // Async reset during the second low phase of an 8086 sequence
    intr = 1'b1; ien = 1'b1; mode = 1'b1; d = 8'h66;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_pre_inta", 0, 16'(inta), 16'h0);
    intr = 1'b1; ien = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_inta", 0, 16'(inta), 16'h1);
    chk("rst_async_busy", 0, 16'(busy), 16'h0);
    chk("rst_async_vv",   0, 16'(vv), 16'h0);
    chk("rst_async_vec",  0, 16'(vector), 16'h00);
    chk("rst_async_ca",   0, call_addr, 16'h0000);
    chk("rst_async_oe",   0, 16'(oe), 16'h0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle_inta", i, 16'(inta), 16'h1);
      chk("post_rst_idle_busy", i, 16'(busy), 16'h0);
    end
    ien = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_start_inta", 0, 16'(inta), 16'h0);
    chk("post_rst_start_busy", 0, 16'(busy), 16'h1);
    intr = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_done_busy", 0, 16'(busy), 16'h0);

    // PULSE_W=1, GAP_W=3 instance: back-to-back sequences with intr held high
    exp_inta_b = 14'b11011101101110;
    exp_busy_b = 14'b01111110111111;
    exp_vv_b   = 14'b01000000100000;
    ien_b = 1'b1; mode_b = 1'b1;
    for (int r = 0; r < 14; r++) begin
      intr_b = (r <= 7);
      d_b    = (r == 5) ? 8'h77 : ((r == 12) ? 8'h99 : 8'h00);
      @(posedge clk);
      #1;
      chk("b_inta", r, 16'(inta_b), 16'(exp_inta_b[r]));
      chk("b_busy", r, 16'(busy_b), 16'(exp_busy_b[r]));
      chk("b_vv",   r, 16'(vv_b), 16'(exp_vv_b[r]));
      if (r == 5)  chk("b_vector", r, 16'(vector_b), 16'h77);
      if (r == 12) chk("b_vector", r, 16'(vector_b), 16'h99);
    end
    chk("b_call_addr", 0, call_addr_b, 16'h0000);
    chk("b_opcode_err", 0, 16'(oe_b), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
